// File: rtl/keypad_evt_if.sv
// Key-event bus between the keypad scanner and its consumers:
// a valid/ready press handshake plus debounced status flags.
interface keypad_evt_if #(
  parameter int unsigned KEY_W = 4
);
  logic             key_valid;
  logic [KEY_W-1:0] key_code;
  logic             key_ready;
  logic             key_held;
  logic             multi_press;
  logic             overflow;

  modport master (
    output key_valid, key_code, key_held, multi_press, overflow,
    input  key_ready
  );

  modport slave (
    input  key_valid, key_code, key_held, multi_press, overflow,
    output key_ready
  );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// Matrix-keypad scanner: one-hot row drive, whole-frame debounce and
// one-shot press events with held / multi-press / overflow status.
module keypad_scan_ctrl #(
  parameter int unsigned N_ROWS   = 4,
  parameter int unsigned N_COLS   = 3,
  parameter int unsigned SCAN_DIV = 1000000,
  parameter int unsigned DEBOUNCE = 3
) (
  input  logic              clk,
  input  logic              init,
  input  logic [N_COLS-1:0] col,
  output logic [N_ROWS-1:0] row,
  keypad_evt_if.master      evt
);

  localparam int unsigned N_KEYS = N_ROWS * N_COLS;
  localparam int unsigned KEY_W  = $clog2(N_KEYS);
  localparam int unsigned PC_W   = KEY_W + 1;
  localparam int unsigned CNT_W  = $clog2(SCAN_DIV);
  localparam int unsigned RIDX_W = $clog2(N_ROWS);
  localparam int unsigned FC_W   = $clog2(DEBOUNCE + 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RIDX_W-1:0] ridx_q, ridx_d;
  logic [N_ROWS-1:0] row_q, row_d;
  logic [N_KEYS-1:0] snap_q, snap_d;
  logic [N_KEYS-1:0] cand_q, cand_d;
  logic [N_KEYS-1:0] deb_q, deb_d;
  logic [FC_W-1:0]   fcnt_q, fcnt_d;
  logic              evt_q, evt_d;
  logic [KEY_W-1:0]  evt_code_q, evt_code_d;
  logic              valid_q, valid_d;
  logic [KEY_W-1:0]  code_q, code_d;
  logic              held_q, held_d;
  logic              multi_q, multi_d;
  logic              ovf_q, ovf_d;
  logic              last_c;

  function automatic logic [PC_W-1:0] popcnt(input logic [N_KEYS-1:0] v);
    logic [PC_W-1:0] n;
    n = '0;
    for (int i = 0; i < int'(N_KEYS); i++) n = n + PC_W'(v[i]);
    return n;
  endfunction

  // Only called on single-bit vectors, so any set bit is the key.
  function automatic logic [KEY_W-1:0] key_idx(input logic [N_KEYS-1:0] v);
    logic [KEY_W-1:0] k;
    k = '0;
    for (int i = 0; i < int'(N_KEYS); i++) if (v[i]) k = KEY_W'(i);
    return k;
  endfunction

  assign last_c = (cnt_q == CNT_W'(SCAN_DIV - 1));

  always_comb begin
    cnt_d      = cnt_q + CNT_W'(1);
    ridx_d     = ridx_q;
    row_d      = row_q;
    snap_d     = snap_q;
    cand_d     = cand_q;
    fcnt_d     = fcnt_q;
    deb_d      = deb_q;
    evt_d      = 1'b0;
    evt_code_d = evt_code_q;
    valid_d    = valid_q;
    code_d     = code_q;
    ovf_d      = ovf_q;
    held_d     = |deb_q;
    multi_d    = (popcnt(deb_q) >= PC_W'(2));

    // End of row dwell: capture columns and advance to the next row.
    if (last_c) begin
      cnt_d  = '0;
      row_d  = {row_q[N_ROWS-2:0], row_q[N_ROWS-1]};
      ridx_d = (ridx_q == RIDX_W'(N_ROWS - 1)) ? '0 : ridx_q + RIDX_W'(1);
      for (int r = 0; r < int'(N_ROWS); r++) begin
        if (ridx_q == RIDX_W'(r)) snap_d[r*N_COLS +: N_COLS] = col;
      end
    end

    // Frame complete: snap_d already holds the last row's columns.
    if (last_c && (ridx_q == RIDX_W'(N_ROWS - 1))) begin
      if (snap_d == cand_q) begin
        if (fcnt_q != FC_W'(DEBOUNCE)) fcnt_d = fcnt_q + FC_W'(1);
      end else begin
        cand_d = snap_d;
        fcnt_d = FC_W'(1);
      end
      if ((fcnt_d == FC_W'(DEBOUNCE)) && (cand_d != deb_q)) begin
        deb_d = cand_d;
        if ((deb_q == '0) && (popcnt(cand_d) == PC_W'(1))) begin
          evt_d      = 1'b1;
          evt_code_d = key_idx(cand_d);
        end
      end
    end

    // An event arriving while one is still unaccepted is dropped.
    if (evt_q) begin
      if (!valid_q || evt.key_ready) begin
        valid_d = 1'b1;
        code_d  = evt_code_q;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (valid_q && evt.key_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      cnt_q      <= '0;
      ridx_q     <= '0;
      row_q      <= N_ROWS'(1);
      snap_q     <= '0;
      cand_q     <= '0;
      fcnt_q     <= '0;
      deb_q      <= '0;
      evt_q      <= 1'b0;
      evt_code_q <= '0;
      valid_q    <= 1'b0;
      code_q     <= '0;
      held_q     <= 1'b0;
      multi_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      ridx_q     <= ridx_d;
      row_q      <= row_d;
      snap_q     <= snap_d;
      cand_q     <= cand_d;
      fcnt_q     <= fcnt_d;
      deb_q      <= deb_d;
      evt_q      <= evt_d;
      evt_code_q <= evt_code_d;
      valid_q    <= valid_d;
      code_q     <= code_d;
      held_q     <= held_d;
      multi_q    <= multi_d;
      ovf_q      <= ovf_d;
    end
  end

  assign row             = row_q;
  assign evt.key_valid   = valid_q;
  assign evt.key_code    = code_q;
  assign evt.key_held    = held_q;
  assign evt.multi_press = multi_q;
  assign evt.overflow    = ovf_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl: 4x3 pad, SCAN_DIV=4, DEBOUNCE=2,
// so one frame is 16 clocks; edge_n counts posedges since init release.
module tb_keypad_scan_ctrl;
  localparam int unsigned NR = 4;
  localparam int unsigned NC = 3;
  localparam int unsigned KW = 4;

  logic          clk;
  logic          init;
  logic [NC-1:0] col;
  logic [NR-1:0] row;
  logic [NR*NC-1:0] keys;

  int edge_n;
  int n_checks;
  int n_pass;

  keypad_evt_if #(.KEY_W(KW)) evt ();

  keypad_scan_ctrl #(
    .N_ROWS(NR), .N_COLS(NC), .SCAN_DIV(4), .DEBOUNCE(2)
  ) dut (
    .clk  (clk),
    .init (init),
    .col  (col),
    .row  (row),
    .evt  (evt.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad model: a closed key shorts its column to its row when driven.
  always_comb begin
    col = '0;
    for (int r = 0; r < int'(NR); r++) begin
      if (row[r]) col = col | keys[r*NC +: NC];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s at edge %0d: observed %0h expected %0h", tag, edge_n, got, exp);
  endtask

  task automatic step_to(input int e);
    while (edge_n < e) begin
      @(posedge clk);
      edge_n++;
    end
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_row"},   32'(row), 32'h1);
    chk({tag, "_valid"}, 32'(evt.key_valid), 32'h0);
    chk({tag, "_code"},  32'(evt.key_code), 32'h0);
    chk({tag, "_held"},  32'(evt.key_held), 32'h0);
    chk({tag, "_multi"}, 32'(evt.multi_press), 32'h0);
    chk({tag, "_ovf"},   32'(evt.overflow), 32'h0);
  endtask

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    edge_n        = 0;
    init          = 1'b1;
    keys          = '0;
    evt.key_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("reset");

    // Row rotation with key 7 (row 2 / col 1) held from the start.
    keys[7] = 1'b1;
    init    = 1'b0;
    edge_n  = 0;
    step_to(3);  chk("row_e3",  32'(row), 32'h1);
    step_to(4);  chk("row_e4",  32'(row), 32'h2);
    step_to(8);  chk("row_e8",  32'(row), 32'h4);
    step_to(12); chk("row_e12", 32'(row), 32'h8);
    step_to(16); chk("row_e16", 32'(row), 32'h1);
    chk("valid_e16", 32'(evt.key_valid), 32'h0);
    step_to(32);
    chk("valid_e32", 32'(evt.key_valid), 32'h0);
    chk("held_e32",  32'(evt.key_held), 32'h0);
    step_to(33);
    chk("valid_e33", 32'(evt.key_valid), 32'h1);
    chk("code_e33",  32'(evt.key_code), 32'd7);
    chk("held_e33",  32'(evt.key_held), 32'h1);
    chk("multi_e33", 32'(evt.multi_press), 32'h0);
    keys = '0;
    step_to(34); chk("valid_e34", 32'(evt.key_valid), 32'h0);
    step_to(48); chk("valid_e48", 32'(evt.key_valid), 32'h0);
    chk("held_e48", 32'(evt.key_held), 32'h1);
    step_to(64); chk("held_e64", 32'(evt.key_held), 32'h1);
    step_to(65); chk("held_e65", 32'(evt.key_held), 32'h0);
    chk("valid_e65", 32'(evt.key_valid), 32'h0);

    // Key 11 closed for one frame only: filtered out.
    keys[11] = 1'b1;
    step_to(80);
    keys = '0;
    step_to(97);  chk("glitch_held_e97",   32'(evt.key_held), 32'h0);
    step_to(113); chk("glitch_held_e113",  32'(evt.key_held), 32'h0);
    chk("glitch_valid_e113", 32'(evt.key_valid), 32'h0);

    // Consumer stalled: second press is dropped and overflow sticks.
    evt.key_ready = 1'b0;
    keys[0] = 1'b1;
    step_to(144); chk("k0_valid_e144", 32'(evt.key_valid), 32'h0);
    step_to(145); chk("k0_valid_e145", 32'(evt.key_valid), 32'h1);
    chk("k0_code_e145", 32'(evt.key_code), 32'd0);
    keys = '0;
    step_to(176);
    keys[4] = 1'b1;
    step_to(208);
    chk("ovf_e208",   32'(evt.overflow), 32'h0);
    chk("valid_e208", 32'(evt.key_valid), 32'h1);
    step_to(209);
    chk("ovf_e209",   32'(evt.overflow), 32'h1);
    chk("code_e209",  32'(evt.key_code), 32'd0);
    chk("valid_e209", 32'(evt.key_valid), 32'h1);
    keys = '0;
    step_to(241);
    chk("valid_e241", 32'(evt.key_valid), 32'h1);
    evt.key_ready = 1'b1;
    step_to(242);
    chk("valid_e242", 32'(evt.key_valid), 32'h0);
    chk("ovf_e242",   32'(evt.overflow), 32'h1);

    // Keys 9 and 11 together, then release 11: status only, no event.
    keys[9]  = 1'b1;
    keys[11] = 1'b1;
    step_to(272); chk("multi_e272", 32'(evt.multi_press), 32'h0);
    step_to(273);
    chk("multi_e273", 32'(evt.multi_press), 32'h1);
    chk("held_e273",  32'(evt.key_held), 32'h1);
    chk("valid_e273", 32'(evt.key_valid), 32'h0);
    keys[11] = 1'b0;
    step_to(305);
    chk("multi_e305", 32'(evt.multi_press), 32'h0);
    chk("held_e305",  32'(evt.key_held), 32'h1);
    chk("valid_e305", 32'(evt.key_valid), 32'h0);
    step_to(306); chk("valid_e306", 32'(evt.key_valid), 32'h0);

    // Pending event then asynchronous init mid-dwell.
    evt.key_ready = 1'b0;
    keys = '0;
    step_to(336);
    keys[7] = 1'b1;
    step_to(374);
    chk("pre_init_valid", 32'(evt.key_valid), 32'h1);
    chk("pre_init_code",  32'(evt.key_code), 32'd7);
    chk("pre_init_row",   32'(row), 32'h2);
    init = 1'b1;
    #1;
    chk_idle_outputs("async_init");
    keys = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    init   = 1'b0;
    edge_n = 0;
    step_to(3);
    chk("resume_row_e3",   32'(row), 32'h1);
    chk("resume_valid_e3", 32'(evt.key_valid), 32'h0);
    step_to(4);
    chk("resume_row_e4",   32'(row), 32'h2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
